// File: rtl/mdu_issue_sched.sv
// Issue scheduler for the MDU issue queue: oldest-ready selection, divider occupancy
// tracking and multiply/divide writeback collision avoidance.
module mdu_issue_sched #(
  parameter int QUEUE_LEN = 8,
  parameter int IDX_W     = 3,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [QUEUE_LEN-1:0] valid_vec,
  input  logic [QUEUE_LEN-1:0] ready_vec,
  input  logic [QUEUE_LEN-1:0] is_div_vec,
  input  logic                 wb_stall,
  output logic                 deq_req,
  output logic [IDX_W-1:0]     deq_idx,
  output logic                 issue_is_div,
  output logic                 div_busy,
  output logic                 wb_valid,
  output logic                 wb_is_div
);

  localparam int CNT_W = $clog2(DIV_LAT);

  typedef enum logic {D_IDLE, D_BUSY} div_state_e;

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MUL_LAT-1:0]   mul_pipe;
  logic                 issue_base;
  logic                 mul_ok;
  logic                 mul_wb;
  logic                 div_wb;
  logic                 div_issue;
  logic                 mul_issue;
  logic [QUEUE_LEN-1:0] eligible;

  assign div_busy   = (state_q == D_BUSY);
  assign div_wb     = div_busy && (cnt_q == '0);
  assign mul_wb     = mul_pipe[MUL_LAT-1];
  assign wb_valid   = mul_wb | div_wb;
  assign wb_is_div  = div_wb;

  // A multiply issued while cnt_q==MUL_LAT would land on the divider's writeback cycle.
  assign issue_base = ~wb_stall & ~flush & ~rst;
  assign mul_ok     = ~(div_busy && (cnt_q == CNT_W'(MUL_LAT)));
  assign eligible   = valid_vec & ready_vec & {QUEUE_LEN{issue_base}} &
                      ((is_div_vec & {QUEUE_LEN{~div_busy}}) |
                       (~is_div_vec & {QUEUE_LEN{mul_ok}}));

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    deq_req      = 1'b0;
    deq_idx      = '0;
    issue_is_div = 1'b0;
    for (int i = QUEUE_LEN - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        deq_req      = 1'b1;
        deq_idx      = IDX_W'(i);
        issue_is_div = is_div_vec[i];
      end
    end
  end

  assign div_issue = deq_req & issue_is_div;
  assign mul_issue = deq_req & ~issue_is_div;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      D_IDLE: begin
        if (div_issue) begin
          state_d = D_BUSY;
          cnt_d   = CNT_W'(DIV_LAT - 1);
        end
      end
      D_BUSY: begin
        if (cnt_q == '0) state_d = D_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = D_IDLE;
    endcase
    if (flush) begin
      state_d = D_IDLE;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= D_IDLE;
      cnt_q    <= '0;
      mul_pipe <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mul_pipe <= flush ? '0 : ((mul_pipe << 1) | MUL_LAT'(mul_issue));
    end
  end

endmodule

// File: tb/tb_mdu_issue_sched.sv
// Self-checking bench for mdu_issue_sched: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a timeline-based model.
module tb_mdu_issue_sched;

  localparam int QUEUE_LEN = 8;
  localparam int IDX_W     = 3;
  localparam int MUL_LAT   = 3;
  localparam int DIV_LAT   = 34;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic [QUEUE_LEN-1:0] valid_vec = '0;
  logic [QUEUE_LEN-1:0] ready_vec = '0;
  logic [QUEUE_LEN-1:0] is_div_vec = '0;
  logic                 wb_stall = 1'b0;
  logic                 deq_req;
  logic [IDX_W-1:0]     deq_idx;
  logic                 issue_is_div;
  logic                 div_busy;
  logic                 wb_valid;
  logic                 wb_is_div;

  mdu_issue_sched #(
    .QUEUE_LEN(QUEUE_LEN), .IDX_W(IDX_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_vec(valid_vec), .ready_vec(ready_vec), .is_div_vec(is_div_vec),
    .wb_stall(wb_stall),
    .deq_req(deq_req), .deq_idx(deq_idx), .issue_is_div(issue_is_div),
    .div_busy(div_busy), .wb_valid(wb_valid), .wb_is_div(wb_is_div)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Model state as absolute-time events: cycle of the last divide issue and
  // the writeback cycles of in-flight multiplies.
  int div_t = -1;
  int mul_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit m_busy, m_div_wb, m_mul_wb, m_req, m_isdiv, ok;
    logic [IDX_W-1:0] m_idx;
    if (mon_en) begin
      m_busy   = (div_t >= 0) && (cyc > div_t) && (cyc <= div_t + DIV_LAT);
      m_div_wb = (div_t >= 0) && (cyc == div_t + DIV_LAT);
      m_mul_wb = 1'b0;
      foreach (mul_q[i]) if (mul_q[i] == cyc) m_mul_wb = 1'b1;
      m_req = 1'b0; m_idx = '0; m_isdiv = 1'b0;
      for (int i = 0; i < QUEUE_LEN; i++) begin
        ok = valid_vec[i] && ready_vec[i] && !wb_stall && !flush && !rst;
        if (is_div_vec[i]) ok = ok && !m_busy;
        else ok = ok && !((div_t >= 0) && (cyc + MUL_LAT == div_t + DIV_LAT));
        if (ok && !m_req) begin
          m_req = 1'b1; m_idx = IDX_W'(i); m_isdiv = is_div_vec[i];
        end
      end
      check("model_issue", {deq_req, deq_idx, issue_is_div}, {m_req, m_idx, m_isdiv});
      check("model_status", {div_busy, wb_valid, wb_is_div},
            {m_busy, m_mul_wb | m_div_wb, m_div_wb});
      if (rst || flush) begin
        div_t = -1;
        mul_q.delete();
      end else if (m_req) begin
        if (m_isdiv) div_t = cyc;
        else mul_q.push_back(cyc + MUL_LAT);
      end
      while (mul_q.size() > 0 && mul_q[0] <= cyc) void'(mul_q.pop_front());
      cyc++;
    end
  end

  task automatic drive(input logic [7:0] v, input logic [7:0] r, input logic [7:0] d,
                       input logic st, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    valid_vec = v; ready_vec = r; is_div_vec = d;
    wb_stall = st; flush = fl; rst = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_state", {deq_req, deq_idx, issue_is_div, div_busy, wb_valid, wb_is_div}, 0);

    // Multiply latency
    drive(8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mul_issue", {deq_req, deq_idx}, 4'b1_000);
    for (int k = 1; k <= 3; k++) begin
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("mul_wb", {wb_valid, wb_is_div}, (k == 3) ? 2'b10 : 2'b00);
    end

    // Oldest-ready selection
    drive(8'h0F, 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("oldest_ready_a", {deq_req, deq_idx}, 4'b1_001);
    drive(8'h0F, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("oldest_ready_b", {deq_req, deq_idx}, 4'b1_011);
    idle(5);

    // Divide busy window with a second divide held ready
    drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("div_issue", {deq_req, deq_idx, issue_is_div}, 5'b1_000_1);
    for (int k = 1; k <= 35; k++) begin
      drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (k <= 34) check("div_window", {div_busy, deq_req}, 2'b10);
      if (k == 34) check("div_wb", {wb_valid, wb_is_div}, 2'b11);
      if (k == 35) check("div_second", {deq_req, issue_is_div, div_busy}, 3'b110);
    end
    idle(40);

    // Collision avoidance: multiplies presented around the divide writeback
    drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 38; k++) begin
      if (k >= 20 && k <= 35) drive(8'h02, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
      else drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (k >= 20 && k <= 35) check("collide_issue", deq_req, (k != 31));
      if (k == 33) check("collide_mwb", {wb_valid, wb_is_div}, 2'b10);
      if (k == 34) check("collide_dwb", {wb_valid, wb_is_div}, 2'b11);
      if (k == 35) check("collide_mwb2", {wb_valid, wb_is_div}, 2'b10);
    end
    idle(5);

    // Divide bypass by a younger multiply
    drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(8'h03, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bypass", {deq_req, deq_idx, issue_is_div}, 5'b1_001_0);
    idle(40);

    // Flush mid-divide, with a multiply in flight and one presented in the flush cycle
    drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    idle(3);
    drive(8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_noissue", deq_req, 1'b0);
    for (int k = 6; k <= 40; k++) begin
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("flush_quiet", {div_busy, wb_valid}, 2'b00);
    end

    // wb_stall blocks issue only
    for (int k = 0; k < 6; k++) begin
      drive(8'h0F, 8'h0F, 8'h05, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("stall_noissue", {deq_req, div_busy}, 2'b00);
    end
    drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      drive(8'h02, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("stall_hold", deq_req, 1'b0);
      if (k == 34) check("stall_div_wb", {wb_valid, wb_is_div}, 2'b11);
    end
    idle(5);

    // Reset mid-divide
    drive(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1);
    drive(8'h0F, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_noissue", deq_req, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_outputs", {deq_req, deq_idx, issue_is_div, div_busy, wb_valid, wb_is_div}, 0);
    for (int k = 7; k <= 40; k++) begin
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("rst_quiet", {div_busy, wb_valid}, 2'b00);
    end

    // Randomized traffic, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      drive(8'($urandom), 8'($urandom | $urandom), 8'($urandom & $urandom & $urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 99) == 0));
    end
    idle(45);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
